// File: rtl/ibex_defines.sv
// Shared ibex definitions: eFPGA opcode plus dispatcher state and error encodings.
package ibex_defines;

  localparam logic [6:0] OPCODE_eFPGA = 7'h0b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } efpga_state_e;

  typedef enum logic [1:0] {
    EFPGA_ERR_NONE    = 2'd0,
    EFPGA_ERR_ILLCH   = 2'd1,
    EFPGA_ERR_TIMEOUT = 2'd2,
    EFPGA_ERR_FAULT   = 2'd3
  } efpga_err_e;

endpackage

// File: rtl/ibex_efpga_watchdog.sv
// Saturating per-request watchdog; expired_o flags the cycle whose increment reaches the limit.
module ibex_efpga_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires in the cycle that performs the TIMEOUT_CYCLES-th increment.
  assign expired_o = enable_i && (cnt_q >= Limit - 1'b1);

endmodule

// File: rtl/ibex_efpga_dispatch.sv
// Multi-channel eFPGA instruction dispatcher: routes operands to a funct3-selected channel,
// returns its result or an error (illegal channel, timeout, channel fault).
module ibex_efpga_dispatch
  import ibex_defines::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  input  logic [2:0]                   funct3_i,
  input  logic [6:0]                   funct7_i,
  input  logic [DATA_WIDTH-1:0]        op_a_i,
  input  logic [DATA_WIDTH-1:0]        op_b_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic                         err_o,
  output logic [1:0]                   err_cause_o,
  output logic [NUM_CH-1:0]            ch_req_o,
  input  logic [NUM_CH-1:0]            ch_gnt_i,
  output logic [6:0]                   ch_op_o,
  output logic [DATA_WIDTH-1:0]        ch_opa_o,
  output logic [DATA_WIDTH-1:0]        ch_opb_o,
  input  logic [NUM_CH-1:0]            ch_rvalid_i,
  input  logic [NUM_CH-1:0]            ch_rerr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata_i
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  efpga_state_e          state_q, state_d;
  efpga_err_e            cause_q, cause_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [6:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  gnt_sel, rvalid_sel, rerr_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  ch_legal;
  logic                  wd_expired;

  ibex_efpga_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q == IDLE),
    .enable_i ((state_q == REQ) || (state_q == WAIT)),
    .expired_o(wd_expired)
  );

  assign ch_legal = ({29'd0, funct3_i} < NUM_CH);

  // Only the selected channel's handshake is visible to the FSM.
  always_comb begin
    gnt_sel    = 1'b0;
    rvalid_sel = 1'b0;
    rerr_sel   = 1'b0;
    rdata_sel  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_W'(k)) begin
        gnt_sel    = ch_gnt_i[k];
        rvalid_sel = ch_rvalid_i[k];
        rerr_sel   = ch_rerr_i[k];
        rdata_sel  = ch_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    sel_d   = sel_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rdata_d = rdata_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            if (ch_legal) begin
              sel_d   = funct3_i[SEL_W-1:0];
              op_d    = funct7_i;
              opa_d   = op_a_i;
              opb_d   = op_b_i;
              state_d = REQ;
            end else begin
              cause_d = EFPGA_ERR_ILLCH;
              rdata_d = '0;
              state_d = DONE;
            end
          end
        end
        REQ: begin
          if (wd_expired) begin
            cause_d = EFPGA_ERR_TIMEOUT;
            rdata_d = '0;
            state_d = DONE;
          end else if (gnt_sel) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (wd_expired) begin
            cause_d = EFPGA_ERR_TIMEOUT;
            rdata_d = '0;
            state_d = DONE;
          end else if (rvalid_sel) begin
            rdata_d = rdata_sel;
            cause_d = rerr_sel ? EFPGA_ERR_FAULT : EFPGA_ERR_NONE;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cause_q <= EFPGA_ERR_NONE;
      sel_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ch_req_o = '0;
    if (state_q == REQ) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (sel_q == SEL_W'(k)) begin
          ch_req_o[k] = 1'b1;
        end
      end
    end
  end

  assign ready_o     = (state_q == IDLE);
  // A flush landing in DONE kills the strobe in the same cycle.
  assign valid_o     = (state_q == DONE) && !flush_i;
  assign rdata_o     = rdata_q;
  assign err_cause_o = cause_q;
  assign err_o       = (cause_q != EFPGA_ERR_NONE);
  assign ch_op_o     = op_q;
  assign ch_opa_o    = opa_q;
  assign ch_opb_o    = opb_q;

endmodule

// File: tb/tb_ibex_efpga_dispatch.sv
// Directed scoreboard bench for ibex_efpga_dispatch (4 channels, 8-cycle watchdog).
module tb_ibex_efpga_dispatch;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [DW-1:0]   op_a, op_b;
  logic            flush;
  logic            ready, valid, err;
  logic [DW-1:0]   rdata;
  logic [1:0]      err_cause;
  logic [NCH-1:0]  ch_req, ch_gnt, ch_rvalid, ch_rerr;
  logic [6:0]      ch_op;
  logic [DW-1:0]   ch_opa, ch_opb;
  logic [NCH*DW-1:0] ch_rdata;

  int evaluated = 0;
  int failures  = 0;
  int valid_seen = 0;
  int valid_exp  = 0;
  logic [33:0] sb_q[$];

  always #5 clk = ~clk;

  ibex_efpga_dispatch #(
    .NUM_CH(NCH),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .funct3_i(funct3), .funct7_i(funct7),
    .op_a_i(op_a), .op_b_i(op_b), .flush_i(flush), .ready_o(ready), .valid_o(valid),
    .rdata_o(rdata), .err_o(err), .err_cause_o(err_cause), .ch_req_o(ch_req),
    .ch_gnt_i(ch_gnt), .ch_op_o(ch_op), .ch_opa_o(ch_opa), .ch_opb_o(ch_opb),
    .ch_rvalid_i(ch_rvalid), .ch_rerr_i(ch_rerr), .ch_rdata_i(ch_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req = 1'b1; funct3 = f3; funct7 = 7'h15; op_a = a; op_b = b;
  endtask

  task automatic expect_result(input logic [DW-1:0] d, input logic [1:0] c);
    sb_q.push_back({c, d});
    valid_exp++;
  endtask

  // Scoreboard monitor: every valid strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_seen++;
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 64'(valid), 64'(0));
      end else begin
        logic [33:0] e;
        e = sb_q.pop_front();
        chk("sb_rdata", 64'(rdata), 64'(e[31:0]));
        chk("sb_cause", 64'(err_cause), 64'(e[33:32]));
        chk("sb_err", 64'(err), 64'(e[33:32] != 2'd0));
      end
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0; flush = 1'b0;
    ch_gnt = '0; ch_rvalid = '0; ch_rerr = '0; ch_rdata = '0;
    tick(); tick();
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_chreq", 64'(ch_req), 64'(0));
    chk("rst_cause", 64'(err_cause), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_chop", 64'({ch_op, ch_opa, ch_opb}), 64'(0));
    rst = 1'b0;
    tick();

    // Minimum-latency legal request to channel 2.
    issue(3'd2, 32'h10, 32'h20);
    expect_result(32'h30, 2'd0);
    tick();
    req = 1'b0; op_a = '1; op_b = '1;
    chk("t1_chreq_c1", 64'(ch_req), 64'(4'b0100));
    chk("t1_opa", 64'(ch_opa), 64'(32'h10));
    chk("t1_opb", 64'(ch_opb), 64'(32'h20));
    chk("t1_op", 64'(ch_op), 64'(7'h15));
    chk("t1_ready_busy", 64'(ready), 64'(0));
    ch_gnt = 4'b0100;
    tick();
    ch_gnt = '0;
    chk("t1_chreq_wait", 64'(ch_req), 64'(0));
    ch_rvalid = 4'b0100; ch_rdata[2*DW +: DW] = 32'h30;
    tick();
    ch_rvalid = '0;
    chk("t1_valid_c3", 64'(valid), 64'(1));
    tick();
    chk("t1_ready_back", 64'(ready), 64'(1));
    chk("t1_valid_once", 64'(valid), 64'(0));

    // Illegal channel.
    issue(3'd5, 32'h1, 32'h2);
    expect_result(32'h0, 2'd1);
    tick();
    req = 1'b0;
    chk("t2_valid_c1", 64'(valid), 64'(1));
    chk("t2_no_chreq", 64'(ch_req), 64'(0));
    tick();
    chk("t2_ready", 64'(ready), 64'(1));

    // Timeout on channel 1: request held TO cycles, valid in cycle TO+1.
    issue(3'd1, 32'h5, 32'h6);
    expect_result(32'h0, 2'd2);
    tick();
    req = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      chk($sformatf("t3_chreq_c%0d", i), 64'(ch_req), 64'(4'b0010));
      chk($sformatf("t3_novalid_c%0d", i), 64'(valid), 64'(0));
      tick();
    end
    chk("t3_valid_timeout", 64'(valid), 64'(1));
    chk("t3_chreq_dropped", 64'(ch_req), 64'(0));
    tick();
    ch_rvalid = 4'b0010; ch_rdata[1*DW +: DW] = 32'hBEEF;
    tick(); tick();
    ch_rvalid = '0;
    chk("t3_late_rvalid", 64'(valid), 64'(0));
    chk("t3_ready", 64'(ready), 64'(1));

    // Channel fault on channel 3.
    issue(3'd3, 32'h7, 32'h8);
    expect_result(32'hDEAD, 2'd3);
    tick();
    req = 1'b0; ch_gnt = 4'b1000;
    tick();
    ch_gnt = '0; ch_rvalid = 4'b1000; ch_rerr = 4'b1000; ch_rdata[3*DW +: DW] = 32'hDEAD;
    tick();
    ch_rvalid = '0; ch_rerr = '0;
    chk("t4_valid", 64'(valid), 64'(1));
    tick();

    // Flush in WAIT, then a stray rvalid, then a clean request to channel 0.
    issue(3'd2, 32'h9, 32'hA);
    tick();
    req = 1'b0; ch_gnt = 4'b0100;
    tick();
    ch_gnt = '0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_ready", 64'(ready), 64'(1));
    chk("t5_flush_novalid", 64'(valid), 64'(0));
    ch_rvalid = 4'b0100; ch_rdata[2*DW +: DW] = 32'hBAD;
    tick();
    ch_rvalid = '0;
    chk("t5_stray_ignored", 64'(valid), 64'(0));
    issue(3'd0, 32'hB, 32'hC);
    expect_result(32'h1234, 2'd0);
    tick();
    req = 1'b0;
    chk("t5_chreq0", 64'(ch_req), 64'(4'b0001));
    ch_gnt = 4'b0001;
    tick();
    ch_gnt = '0; ch_rvalid = 4'b0001; ch_rdata[0 +: DW] = 32'h1234;
    tick();
    ch_rvalid = '0;
    chk("t5_valid", 64'(valid), 64'(1));
    tick();

    // Flush during DONE suppresses the strobe.
    issue(3'd6, 32'h0, 32'h0);
    tick();
    req = 1'b0; flush = 1'b1;
    #1;
    chk("t6_flush_done", 64'(valid), 64'(0));
    tick();
    flush = 1'b0;
    chk("t6_ready", 64'(ready), 64'(1));

    // Reset in REQ.
    issue(3'd1, 32'h1, 32'h1);
    tick();
    req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_chreq", 64'(ch_req), 64'(0));
    chk("t7_rst_ready", 64'(ready), 64'(1));
    chk("t7_rst_novalid", 64'(valid), 64'(0));

    // Non-selected rvalid in WAIT is ignored.
    issue(3'd1, 32'h3, 32'h4);
    expect_result(32'h55, 2'd0);
    tick();
    req = 1'b0; ch_gnt = 4'b0010;
    tick();
    ch_gnt = '0; ch_rvalid = 4'b0100; ch_rdata[2*DW +: DW] = 32'h99;
    tick();
    ch_rvalid = 4'b0010; ch_rdata[1*DW +: DW] = 32'h55;
    chk("t8_other_ignored", 64'(valid), 64'(0));
    chk("t8_still_busy", 64'(ready), 64'(0));
    tick();
    ch_rvalid = '0;
    chk("t8_valid", 64'(valid), 64'(1));
    tick(); tick();

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    chk("valid_count", 64'(valid_seen), 64'(valid_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule

// File: doc/ibex_efpga_dispatch.md
# ibex_efpga_dispatch

Multi-channel dispatcher for the custom eFPGA instruction (major opcode 7'h0b). It sits beside the ALU and multiplier/divider in the ibex EX stage. It takes one decoded eFPGA instruction at a time and routes its operands to one of `NUM_CH` accelerator channels selected by funct3. It returns the channel's result, or an error on an illegal channel, a timeout or a channel-reported fault. It generalises the single fixed eFPGA slot to a parametrised channel count, adds a per-request watchdog and supports flush.

## Interface
Parameters:
- `NUM_CH`, 4: number of accelerator channels, 1..8.
- `DATA_WIDTH`, 32: operand/result width.
- `TIMEOUT_CYCLES`, 255: maximum cycles in REQ+WAIT before abort, ≥2.
- `CNT_W`, `$clog2(TIMEOUT_CYCLES+1)`: watchdog counter width (derived).

Ports:
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  one-cycle instruction issue; sampled only in IDLE.
- `funct3_i`  in  3  channel select.
- `funct7_i`  in  7  operation code forwarded to the channel.
- `op_a_i`, `op_b_i`  in  DATA_WIDTH  operands.
- `flush_i`  in  1  abort the current request.
- `ready_o`  out  1  high in IDLE.
- `valid_o`  out  1  one-cycle result strobe.
- `rdata_o`  out  DATA_WIDTH  result, qualified by `valid_o`.
- `err_o`  out  1  error flag, qualified by `valid_o`.
- `err_cause_o`  out  2  0 = none, 1 = illegal channel, 2 = timeout, 3 = channel fault.
- `ch_req_o`  out  NUM_CH  one-hot request to the channels.
- `ch_gnt_i`  in  NUM_CH  per-channel grant.
- `ch_op_o`  out  7  registered funct7, shared by all channels.
- `ch_opa_o`, `ch_opb_o`  out  DATA_WIDTH  registered operands, shared by all channels.
- `ch_rvalid_i`  in  NUM_CH  per-channel result valid.
- `ch_rerr_i`  in  NUM_CH  per-channel fault, qualified by that channel's rvalid.
- `ch_rdata_i`  in  NUM_CH*DATA_WIDTH  packed results; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `req_i` with `funct3_i < NUM_CH`: latch the channel, funct7 and operands, clear the watchdog, go to REQ.
  - On `req_i` with `funct3_i >= NUM_CH`: latch err_cause = 1 and rdata = 0, go to DONE. No channel is requested.
- **REQ**
  - `ch_req_o[sel]` = 1; all other bits of `ch_req_o` = 0. Latched operands are held stable.
  - On `ch_gnt_i[sel]`: go to WAIT. `ch_req_o` drops in WAIT.
  - Grants from non-selected channels are ignored.
- **WAIT**
  - On `ch_rvalid_i[sel]`: capture `ch_rdata_i[sel]`. Set err_cause = 3 if `ch_rerr_i[sel]`, else 0. Go to DONE.
  - A grant and rvalid arriving in the same cycle while in REQ are not merged. The channel must hold rvalid until the dispatcher is in WAIT.
- **DONE**
  - `valid_o` = 1 for exactly one cycle, together with the latched `rdata_o`, `err_o` (err_cause != 0) and `err_cause_o`.
  - Go to IDLE.
- **Watchdog**
  - Increments every cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`: go to DONE with err_cause = 2 and rdata = 0, and drop `ch_req_o`.
  - A timeout has priority over a grant or rvalid in the same cycle.
- **flush_i**
  - In any state: go to IDLE next cycle. No `valid_o` is produced and `ch_req_o` is cleared.
  - A flush in DONE suppresses `valid_o` in that cycle.
  - Flush has priority over all other events. Flush and `req_i` together in IDLE: the request is dropped.
- **Stray inputs**: `ch_rvalid_i` in IDLE/REQ/DONE and from non-selected channels is ignored. A late response from a flushed or timed-out request is therefore discarded.

## Timing
- Reset values:
  - state = IDLE, `ready_o` = 1.
  - `valid_o`, `err_o`, `ch_req_o` = 0.
  - `err_cause_o` = 0, `rdata_o` = 0.
  - `ch_op_o`, `ch_opa_o`, `ch_opb_o` = 0.
  - watchdog = 0.
- All outputs are registered or decoded from state/registers only. There is no combinational path from any `ch_*_i` or `req_i` to any output.
- Minimum latency, legal channel, grant and rvalid each arriving as early as possible:
  - `req_i` in cycle 0.
  - `ch_req_o` in cycle 1, grant in cycle 1.
  - rvalid in cycle 2.
  - `valid_o` in cycle 3.
- Illegal channel: `req_i` in cycle 0, `valid_o` with err_cause 1 in cycle 1.
- Timeout: with no grant, `valid_o` with err_cause 2 appears `TIMEOUT_CYCLES`+1 cycles after `req_i`.
- Back-to-back: `ready_o` returns the cycle after DONE, so the next `req_i` can be accepted at the earliest 1 cycle after `valid_o`.
- Reset asserted mid-operation: the block is in the reset state on the next edge and no `valid_o` is emitted.

## Structure
- Add to the shared `ibex_defines` package:
  - `efpga_state_e` (IDLE/REQ/WAIT/DONE).
  - `efpga_err_e` (EFPGA_ERR_NONE/ILLCH/TIMEOUT/FAULT).
  - `OPCODE_eFPGA`, which stays there.
- One sub-module, `ibex_efpga_watchdog`:
  - clear/enable inputs, `expired_o` output, parametrised by `TIMEOUT_CYCLES`.
  - saturating, so it never wraps.

## Test plan
- `NUM_CH`=4, `req_i` with funct3=2, op_a=0x10, op_b=0x20. Channel 2 grants immediately and returns 0x30 next cycle -> `ch_req_o`=4'b0100 in cycle 1, `valid_o` in cycle 3, `rdata_o`=0x30, `err_o`=0.
- funct3=5 -> no `ch_req_o` bit ever set; `valid_o` in cycle 1 with `err_cause_o`=1 and `rdata_o`=0.
- `TIMEOUT_CYCLES`=8, channel 1 never grants -> `ch_req_o`=4'b0010 for 8 cycles; `valid_o` in cycle 9 with `err_cause_o`=2. A later rvalid on channel 1 produces no `valid_o`.
- Grant, then channel 3 returns rvalid with `ch_rerr_i`[3]=1 and data 0xDEAD -> `valid_o` with `err_cause_o`=3 and `rdata_o`=0xDEAD.
- `flush_i` in WAIT -> IDLE next cycle, `ready_o`=1. The subsequent rvalid is ignored, and a new request to channel 0 completes normally with its own data.
- `rst_i` in REQ -> next cycle `ch_req_o`=0 and `ready_o`=1, with no `valid_o`. A simultaneous rvalid on channel 2 while in WAIT for channel 1 is ignored.
